// File: rtl/calc_seq_pkg.sv
// Shared types and constants for the calculator self-test sequencer.
// Step entries pack as {op[2:0], operand[15:0], expected[15:0]}.
package calc_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  localparam int ENTRY_W = 35;
  localparam int EXP_LSB = 0;
  localparam int EXP_MSB = 15;
  localparam int SW_LSB  = 16;
  localparam int SW_MSB  = 31;
  localparam int OP_LSB  = 32;
  localparam int OP_MSB  = 34;

  localparam logic [3:0] FAIL_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  op;
    logic [15:0] operand;
    logic [15:0] expected;
  } entry_t;

  function automatic entry_t mk_entry(input logic [2:0] op, input logic [15:0] operand,
                                      input logic [15:0] expected);
    mk_entry = '{op: op, operand: operand, expected: expected};
  endfunction

endpackage

// File: rtl/calc_seq_rom.sv
// Constant step table. The calculator's op encoding is 0 add, 1 sub, 2 and, 3 or,
// 4 xor, 6 load; expected values track a cleared accumulator through the sequence.
module calc_seq_rom
  import calc_seq_pkg::*;
(
  input  logic [3:0]         addr,
  output logic [ENTRY_W-1:0] data
);

  entry_t e;

  always_comb begin
    e = '0;
    case (addr)
      4'd0:    e = mk_entry(3'd0, 16'h354A, 16'h354A);
      4'd1:    e = mk_entry(3'd0, 16'h1111, 16'h465B);
      4'd2:    e = mk_entry(3'd1, 16'h005B, 16'h4600);
      4'd3:    e = mk_entry(3'd4, 16'h00FF, 16'h46FF);
      4'd4:    e = mk_entry(3'd2, 16'h0FF0, 16'h06F0);
      4'd5:    e = mk_entry(3'd3, 16'h8001, 16'h86F1);
      4'd6:    e = mk_entry(3'd0, 16'h7A0F, 16'h0100);
      4'd7:    e = mk_entry(3'd1, 16'h0001, 16'h00FF);
      4'd8:    e = mk_entry(3'd6, 16'h1234, 16'h1234);
      default: e = '0;
    endcase
  end

  assign data = e;

endmodule

// File: rtl/calc_sequencer.sv
// Drives a calculator through a fixed table of steps, checks each result on led_in
// and reports error count, first failing step and pass/done status.
module calc_sequencer
  import calc_seq_pkg::*;
#(
  parameter int NUM_STEPS = 9,
  parameter int SETTLE    = 2
) (
  input  logic        clk,
  input  logic        btnu,
  input  logic        start,
  input  logic        stop,
  input  logic [15:0] led_in,
  output logic        calc_btnu,
  output logic        calc_btnl,
  output logic        calc_btnc,
  output logic        calc_btnr,
  output logic        calc_btnd,
  output logic [15:0] calc_sw,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [4:0]  err_count,
  output logic [3:0]  fail_idx,
  output logic [3:0]  step_idx
);

  localparam logic [3:0] LAST_STEP   = 4'(NUM_STEPS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_e             state;
  logic [3:0]         wait_cnt;
  logic [3:0]         rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic [2:0]         rd_op;
  logic [15:0]        rd_sw;
  logic [15:0]        rd_exp;
  logic [15:0]        exp_q;
  logic               mismatch;

  // CHECK prefetches the next entry so SETUP already has it on the registered outputs.
  assign rd_addr  = (state == S_CHECK) ? step_idx + 4'd1 : step_idx;
  assign rd_op    = rd_data[OP_MSB:OP_LSB];
  assign rd_sw    = rd_data[SW_MSB:SW_LSB];
  assign rd_exp   = rd_data[EXP_MSB:EXP_LSB];
  assign mismatch = (led_in != exp_q);

  calc_seq_rom u_rom (
    .addr (rd_addr),
    .data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (btnu) begin
      state     <= S_IDLE;
      calc_btnu <= 1'b0;
      calc_btnl <= 1'b0;
      calc_btnc <= 1'b0;
      calc_btnr <= 1'b0;
      calc_btnd <= 1'b0;
      calc_sw   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_idx  <= FAIL_NONE;
      step_idx  <= '0;
      wait_cnt  <= '0;
      exp_q     <= '0;
    end else if (busy && stop) begin
      // abort keeps the diagnostic counters so the partial run can be inspected
      state     <= S_IDLE;
      calc_btnu <= 1'b0;
      calc_btnl <= 1'b0;
      calc_btnc <= 1'b0;
      calc_btnr <= 1'b0;
      calc_btnd <= 1'b0;
      calc_sw   <= '0;
      busy      <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      calc_btnu <= 1'b0;
      calc_btnd <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            state     <= S_CLEAR;
            calc_btnu <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_idx  <= FAIL_NONE;
            step_idx  <= '0;
          end
        end
        S_CLEAR: begin
          state                             <= S_SETUP;
          {calc_btnl, calc_btnc, calc_btnr} <= rd_op;
          calc_sw                           <= rd_sw;
          exp_q                             <= rd_exp;
        end
        S_SETUP: begin
          state     <= S_STROBE;
          calc_btnd <= 1'b1;
        end
        S_STROBE: begin
          state    <= S_WAIT;
          wait_cnt <= '0;
        end
        S_WAIT: begin
          if (wait_cnt == SETTLE_LAST) begin
            state    <= S_CHECK;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + 5'd1;
            if (fail_idx == FAIL_NONE) fail_idx <= step_idx;
          end
          if (step_idx == LAST_STEP) begin
            state                             <= S_DONE;
            busy                              <= 1'b0;
            done                              <= 1'b1;
            pass                              <= (err_count == 5'd0) && !mismatch;
            {calc_btnl, calc_btnc, calc_btnr} <= 3'b000;
            calc_sw                           <= '0;
          end else begin
            state                             <= S_SETUP;
            step_idx                          <= step_idx + 4'd1;
            {calc_btnl, calc_btnc, calc_btnr} <= rd_op;
            calc_sw                           <= rd_sw;
            exp_q                             <= rd_exp;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural calculator plus a run-phase reference model
// compared every cycle, directed scenarios with literal expectations, then random traffic.
module tb_calc_sequencer;

  localparam int N = 9;
  localparam int S = 2;
  localparam int P = 3 + S;

  logic        clk = 1'b0;
  logic        btnu = 1'b1, start = 1'b0, stop = 1'b0;
  logic        start1 = 1'b0, stop1 = 1'b0;
  logic [15:0] led_in, led1;

  logic        c_btnu, c_l, c_c, c_r, c_btnd, busy, done, pass;
  logic [15:0] c_sw;
  logic [4:0]  err;
  logic [3:0]  fidx, step;

  logic        c1_btnu, c1_l, c1_c, c1_r, c1_btnd, busy1, done1, pass1;
  logic [15:0] c1_sw;
  logic [4:0]  err1;
  logic [3:0]  fidx1, step1;

  int n_vec = 0, n_bad = 0, cyc = 0, corrupt = -1, nstrb = 0;
  bit chk_en = 1'b0;
  logic [15:0] acc = '0, acc1 = '0;

  logic [2:0]  op_t  [0:N-1] = '{3'd0, 3'd0, 3'd1, 3'd4, 3'd2, 3'd3, 3'd0, 3'd1, 3'd6};
  logic [15:0] sw_t  [0:N-1] = '{16'h354A, 16'h1111, 16'h005B, 16'h00FF, 16'h0FF0,
                                 16'h8001, 16'h7A0F, 16'h0001, 16'h1234};
  logic [15:0] exp_t [0:N-1] = '{16'h354A, 16'h465B, 16'h4600, 16'h46FF, 16'h06F0,
                                 16'h86F1, 16'h0100, 16'h00FF, 16'h1234};

  // reference model state: run active, cycle-in-run, outcome
  bit m_run = 1'b0, m_done = 1'b0;
  int m_r = 0, m_err = 0, m_fidx = 15, m_step = 0;

  calc_sequencer #(.NUM_STEPS(N), .SETTLE(S)) u_dut (
    .clk(clk), .btnu(btnu), .start(start), .stop(stop), .led_in(led_in),
    .calc_btnu(c_btnu), .calc_btnl(c_l), .calc_btnc(c_c), .calc_btnr(c_r),
    .calc_btnd(c_btnd), .calc_sw(c_sw), .busy(busy), .done(done), .pass(pass),
    .err_count(err), .fail_idx(fidx), .step_idx(step)
  );

  calc_sequencer #(.NUM_STEPS(1), .SETTLE(S)) u_one (
    .clk(clk), .btnu(btnu), .start(start1), .stop(stop1), .led_in(led1),
    .calc_btnu(c1_btnu), .calc_btnl(c1_l), .calc_btnc(c1_c), .calc_btnr(c1_r),
    .calc_btnd(c1_btnd), .calc_sw(c1_sw), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_idx(fidx1), .step_idx(step1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a, b);
    case (op)
      3'd0:    alu = a + b;
      3'd1:    alu = a - b;
      3'd2:    alu = a & b;
      3'd3:    alu = a | b;
      3'd4:    alu = a ^ b;
      3'd5:    alu = a << b[3:0];
      3'd6:    alu = b;
      default: alu = ~a;
    endcase
  endfunction

  // calculators: accumulate on strobe, cleared only by their own reset button
  always @(posedge clk) begin
    if (c_btnu === 1'b1) begin
      acc   <= '0;
      nstrb <= 0;
    end else if (c_btnd === 1'b1) begin
      acc   <= alu({c_l, c_c, c_r}, acc, c_sw);
      nstrb <= nstrb + 1;
    end
  end
  assign led_in = (corrupt >= 0 && nstrb == corrupt + 1) ? 16'hFFFF : acc;

  always @(posedge clk) begin
    if (c1_btnu === 1'b1)      acc1 <= '0;
    else if (c1_btnd === 1'b1) acc1 <= alu({c1_l, c1_c, c1_r}, acc1, c1_sw);
  end
  assign led1 = acc1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_vec++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // compare on the falling edge, then advance the model across the next rising edge
  initial begin : cmp
    int k, ph;
    logic [36:0] e, a;
    forever begin
      @(negedge clk);
      k  = (m_r >= 2) ? (m_r - 2) / P : 0;
      ph = (m_r >= 2) ? (m_r - 2) % P : -1;
      if (k > N - 1) k = N - 1;
      if (chk_en) begin
        e = {m_run, m_done, m_done && m_err == 0, m_run && m_r == 1,
             (m_run && m_r >= 2) ? op_t[k] : 3'd0, m_run && ph == 1,
             (m_run && m_r >= 2) ? sw_t[k] : 16'h0000,
             5'(m_err), 4'(m_fidx), m_run ? 4'(k) : 4'(m_step)};
        a = {busy, done, pass, c_btnu, c_l, c_c, c_r, c_btnd, c_sw, err, fidx, step};
        chk("cycle", 64'(a), 64'(e));
      end
      if (btnu) begin
        m_run = 1'b0; m_done = 1'b0; m_err = 0; m_fidx = 15; m_step = 0;
      end else if (m_run) begin
        if (stop) begin
          m_run  = 1'b0;
          m_step = k;
        end else begin
          if (m_r >= 2 && ph == P - 1) begin
            if (led_in != exp_t[k]) begin
              m_err++;
              if (m_fidx == 15) m_fidx = k;
            end
            if (k == N - 1) begin
              m_run = 1'b0; m_done = 1'b1; m_step = k;
            end
          end
          m_r++;
        end
      end else if (start) begin
        m_run = 1'b1; m_r = 1; m_err = 0; m_fidx = 15; m_step = 0; m_done = 1'b0;
      end
    end
  end

  // waits for done on the main instance; start re-pulsed at pulse_at and pulse_at+20
  task automatic wait_done(input int k0, input int pulse_at, output int lat);
    lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) begin
        lat = cyc - k0;
        break;
      end
      start = (pulse_at >= 0 && (i == pulse_at || i == pulse_at + 20));
      tick();
    end
    start = 1'b0;
  endtask

  initial begin : stim
    int k0, lat, nd;

    // reset for one cycle
    tick();
    btnu = 1'b0;
    chk_en = 1'b1;
    chk("rst_ctl", 64'({busy, done, pass, c_btnu, c_l, c_c, c_r, c_btnd}), 64'h0);
    chk("rst_sw", 64'(c_sw), 64'h0);
    chk("rst_cnt", 64'({err, fidx, step}), 64'({5'd0, 4'hF, 4'd0}));
    chk("rst_one", 64'({busy1, done1, c1_btnd, c1_sw, fidx1}), 64'({3'b000, 16'h0, 4'hF}));

    // single-step build
    start1 = 1'b1; k0 = cyc; tick(); start1 = 1'b0;
    nd = 0; lat = -1;
    for (int i = 0; i < 40; i++) begin
      if (c1_btnd) nd++;
      if (done1 === 1'b1 && lat < 0) lat = cyc - k0;
      tick();
    end
    chk("one_lat", 64'(lat), 64'd7);
    chk("one_strobes", 64'(nd), 64'd1);
    chk("one_result", 64'({pass1, busy1, err1, fidx1, step1}), 64'({2'b10, 5'd0, 4'hF, 4'd0}));
    chk("one_acc", 64'(acc1), 64'h354A);

    // nine steps with step 2 reading back wrong
    corrupt = 2;
    start = 1'b1; k0 = cyc; tick(); start = 1'b0;
    wait_done(k0, -1, lat);
    chk("bad_lat", 64'(lat), 64'd47);
    chk("bad_err", 64'(err), 64'd1);
    chk("bad_fidx", 64'(fidx), 64'd2);
    chk("bad_pass", 64'({done, pass}), 64'b10);
    corrupt = -1;
    tick();

    // restart from DONE, with ignored starts mid-run
    start = 1'b1; k0 = cyc; tick(); start = 1'b0;
    chk("rerun_clr", 64'({err, fidx, done}), 64'({5'd0, 4'hF, 1'b0}));
    wait_done(k0, 10, lat);
    chk("good_lat", 64'(lat), 64'd47);
    chk("good_pass", 64'({done, pass, err, fidx}), 64'({2'b11, 5'd0, 4'hF}));
    chk("good_acc", 64'(acc), 64'h1234);
    tick();

    // stop in WAIT of step 3
    start = 1'b1; k0 = cyc; tick(); start = 1'b0;
    while (cyc < k0 + 19) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_state", 64'({busy, done, step, c_sw}), 64'({2'b00, 4'd3, 16'h0}));
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (c_btnd) nd++;
      tick();
    end
    chk("stop_strobes", 64'(nd), 64'd0);

    // reset during STROBE of step 1 after a failing step 0
    corrupt = 0;
    start = 1'b1; k0 = cyc; tick(); start = 1'b0;
    while (cyc < k0 + 8) tick();
    chk("pre_rst", 64'({c_btnd, err, fidx}), 64'({1'b1, 5'd1, 4'd0}));
    btnu = 1'b1; tick(); btnu = 1'b0;
    chk("mid_rst", 64'({c_btnd, busy, done, err, fidx, step}),
        64'({3'b000, 5'd0, 4'hF, 4'd0}));
    corrupt = -1;

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 59) == 0);
      btnu  = ($urandom_range(0, 399) == 0);
      if (start && !busy) corrupt = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : -1;
      tick();
    end
    start = 1'b0; stop = 1'b0; btnu = 1'b0;
    repeat (60) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
